// File: rtl/psr_cond_unit.sv
// psr_cond_unit: processor status register (N/Z/F/L/C) with a one-deep shadow
// and a registered branch-condition resolver. Define PSR_BYPASS_EN to resolve on next-state flags.
module psr_cond_unit #(
  parameter int WIDTH     = 16,
  parameter int COND_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     alu_flags,
  input  logic                 flag_we,
  input  logic [4:0]           flag_mask,
  input  logic                 spr_we,
  input  logic [WIDTH-1:0]     spr_data,
  input  logic                 psr_save,
  input  logic                 psr_restore,
  input  logic                 cond_valid,
  input  logic [COND_BITS-1:0] cond_code,
  output logic [WIDTH-1:0]     psr_out,
  output logic                 take_valid,
  output logic                 take
);

  localparam int NUM_FLAGS = 5;
  // Internal flag index matches the flag_mask bit order {N,Z,F,L,C}.
  localparam int IDX_C = 0;
  localparam int IDX_L = 1;
  localparam int IDX_F = 2;
  localparam int IDX_Z = 3;
  localparam int IDX_N = 4;

  localparam int POS_C = 0;
  localparam int POS_L = 2;
  localparam int POS_F = 5;
  localparam int POS_Z = 6;
  localparam int POS_N = 7;

  function automatic int flag_pos(input int idx);
    case (idx)
      IDX_C:   return POS_C;
      IDX_L:   return POS_L;
      IDX_F:   return POS_F;
      IDX_Z:   return POS_Z;
      default: return POS_N;
    endcase
  endfunction

  function automatic logic cond_eval(input logic [3:0] code,
                                     input logic [NUM_FLAGS-1:0] f);
    logic n, z, fl, l, c;
    n  = f[IDX_N];
    z  = f[IDX_Z];
    fl = f[IDX_F];
    l  = f[IDX_L];
    c  = f[IDX_C];
    case (code)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return l;
      4'h5:    return !l;
      4'h6:    return n;
      4'h7:    return !n;
      4'h8:    return fl;
      4'h9:    return !fl;
      4'hA:    return !l && !z;
      4'hB:    return l || z;
      4'hC:    return !n && !z;
      4'hD:    return n || z;
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [NUM_FLAGS-1:0] alu_vec;
  logic [NUM_FLAGS-1:0] spr_vec;
  logic [NUM_FLAGS-1:0] live_reg;
  logic [NUM_FLAGS-1:0] live_next;
  logic [NUM_FLAGS-1:0] shadow_reg;
  logic [NUM_FLAGS-1:0] shadow_next;
  logic [NUM_FLAGS-1:0] eval_flags;
  logic                 take_valid_reg;
  logic                 take_reg;
  logic                 unused_inputs;

  // Only the five architectural bit positions of the WIDTH-wide buses matter.
  assign unused_inputs = ^{alu_flags, spr_data};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag_in
      localparam int POS = flag_pos(gi);
      assign alu_vec[gi] = alu_flags[POS];
      assign spr_vec[gi] = spr_data[POS];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_psr_out
      if (gi == POS_C) begin : g_c
        assign psr_out[gi] = live_reg[IDX_C];
      end else if (gi == POS_L) begin : g_l
        assign psr_out[gi] = live_reg[IDX_L];
      end else if (gi == POS_F) begin : g_f
        assign psr_out[gi] = live_reg[IDX_F];
      end else if (gi == POS_Z) begin : g_z
        assign psr_out[gi] = live_reg[IDX_Z];
      end else if (gi == POS_N) begin : g_n
        assign psr_out[gi] = live_reg[IDX_N];
      end else begin : g_zero
        assign psr_out[gi] = 1'b0;
      end
    end
  endgenerate

  // Restore beats LPR beats ALU commit; the losers are simply dropped.
  always_comb begin
    live_next = live_reg;
    if (psr_restore) begin
      live_next = shadow_reg;
    end else if (spr_we) begin
      live_next = spr_vec;
    end else if (flag_we) begin
      live_next = (live_reg & ~flag_mask) | (alu_vec & flag_mask);
    end
  end

  // Shadow always captures the pre-edge live value, which makes save+restore a swap.
  always_comb begin
    shadow_next = shadow_reg;
    if (psr_save) begin
      shadow_next = live_reg;
    end
  end

`ifdef PSR_BYPASS_EN
  assign eval_flags = live_next;
`else
  assign eval_flags = live_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_reg       <= '0;
      shadow_reg     <= '0;
      take_valid_reg <= 1'b0;
      take_reg       <= 1'b0;
    end else begin
      live_reg       <= live_next;
      shadow_reg     <= shadow_next;
      take_valid_reg <= cond_valid;
      take_reg       <= cond_valid && cond_eval(4'(cond_code), eval_flags);
    end
  end

  assign take_valid = take_valid_reg;
  assign take       = take_reg;

endmodule
